// File: rtl/mul_seq.sv
// RV32M multiply sequencer: sign-fix, 32 shift-add steps and result negation on a shared external adder.
// Fixed 37-cycle busy window, done pulses one cycle later; i_start is ignored while busy (no queueing).
module mul_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [31:0] o_add_a,
    output logic [31:0] o_add_b,
    output logic        o_add_cin,
    input  logic [31:0] i_add_sum,
    input  logic        i_add_cout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NEG_A  = 3'd1;
    localparam logic [2:0] ST_NEG_B  = 3'd2;
    localparam logic [2:0] ST_ITER   = 3'd3;
    localparam logic [2:0] ST_FIX_LO = 3'd4;
    localparam logic [2:0] ST_FIX_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic [2:0]  state_q,  state_d;
    logic [1:0]  op_q,     op_d;
    logic [31:0] rs1_q,    rs1_d;
    logic [31:0] rs2_q,    rs2_d;
    logic        sa_q,     sa_d;
    logic        sb_q,     sb_d;
    logic        nr_q,     nr_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] lo_q,     lo_d;
    logic [31:0] hi_q,     hi_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic        c_q,      c_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        nr_d     = nr_q;
        mcand_d  = mcand_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        done_d   = 1'b0;
        add_a    = 32'd0;
        add_b    = 32'd0;
        add_cin  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    op_d    = i_op;
                    rs1_d   = i_rs1;
                    rs2_d   = i_rs2;
                    sa_d    = i_rs1[31] & ((i_op == OP_MULH) | (i_op == OP_MULHSU));
                    sb_d    = i_rs2[31] & (i_op == OP_MULH);
                    nr_d    = (i_rs1[31] & ((i_op == OP_MULH) | (i_op == OP_MULHSU)))
                            ^ (i_rs2[31] & (i_op == OP_MULH));
                    state_d = ST_NEG_A;
                end
            end
            ST_NEG_A: begin
                // Unsigned operands still pass through the adder so latency never depends on data.
                add_a   = sa_q ? ~rs1_q : rs1_q;
                add_cin = sa_q;
                mcand_d = i_add_sum;
                state_d = ST_NEG_B;
            end
            ST_NEG_B: begin
                add_a   = sb_q ? ~rs2_q : rs2_q;
                add_cin = sb_q;
                lo_d    = i_add_sum;
                hi_d    = 32'd0;
                cnt_d   = 5'd31;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                // Multiplier bits shift out of lo while product bits shift into its top.
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : 32'd0;
                hi_d  = {i_add_cout, i_add_sum[31:1]};
                lo_d  = {i_add_sum[0], lo_q[31:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX_LO;
                end
            end
            ST_FIX_LO: begin
                add_a   = nr_q ? ~lo_q : lo_q;
                add_cin = nr_q;
                lo_d    = i_add_sum;
                c_d     = i_add_cout;
                state_d = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                add_a   = nr_q ? ~hi_q : hi_q;
                add_cin = nr_q & c_q;
                hi_d    = i_add_sum;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d = (op_q == OP_MUL) ? lo_q : hi_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            nr_q     <= 1'b0;
            mcand_q  <= 32'd0;
            lo_q     <= 32'd0;
            hi_q     <= 32'd0;
            cnt_q    <= 5'd0;
            c_q      <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            nr_q     <= nr_d;
            mcand_q  <= mcand_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = done_q;
    assign o_result  = result_q;
    assign o_add_a   = add_a;
    assign o_add_b   = add_b;
    assign o_add_cin = add_cin;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random checks of mul_seq against a 64-bit reference product, using a behavioural adder.
module tb_mul_seq;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic [31:0] o_add_a;
    logic [31:0] o_add_b;
    logic        o_add_cin;
    logic [31:0] i_add_sum;
    logic        i_add_cout;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    assign {i_add_cout, i_add_sum} = {1'b0, o_add_a} + {1'b0, o_add_b} + {32'd0, o_add_cin};

    mul_seq dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_add_a    (o_add_a),
        .o_add_b    (o_add_b),
        .o_add_cin  (o_add_cin),
        .i_add_sum  (i_add_sum),
        .i_add_cout (i_add_cout)
    );

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy_done"}, {30'd0, o_busy, o_done}, 32'd0);
        check({tag, "_result"}, o_result, 32'd0);
        check({tag, "_add"}, o_add_a | o_add_b | {31'd0, o_add_cin}, 32'd0);
    endtask

    // Called #1 after an edge; start is sampled on the next edge, then operands are scrambled.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_op    = 2'($urandom_range(3, 0));
        i_rs1   = $urandom;
        i_rs2   = $urandom;
    endtask

    task automatic wait_done(input bit glitch, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!o_done && lat < 60) begin
            if (o_busy) busy_n++;
            if (glitch && (lat == 4 || lat == 19 || lat == 36)) begin
                i_start = 1'b1;
                i_op    = 2'($urandom_range(3, 0));
                i_rs1   = $urandom;
                i_rs2   = $urandom;
            end else begin
                i_start = 1'b0;
            end
            @(posedge i_clk); #1;
            lat++;
        end
        i_start = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        logic [31:0] exp;
        check({tag, "_done"}, {31'd0, o_done}, 32'd1);
        if (o_done && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, o_result, exp);
        end
        check({tag, "_add_idle"}, o_add_a | o_add_b | {31'd0, o_add_cin}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit timing);
        int lat;
        int busy_n;
        exp_q.push_back(exp);
        start_op(op, a, b);
        wait_done(1'b0, lat, busy_n);
        if (timing) begin
            check({tag, "_latency"}, 32'(lat), 32'd37);
            check({tag, "_busy_cycles"}, 32'(busy_n), 32'd37);
        end
        finish_op(tag);
    endtask

    initial begin
        int lat;
        int busy_n;
        int extra;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_op    = 2'd0;
        i_rs1   = 32'd0;
        i_rs2   = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs_zero("reset");
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);

        // Start pulses with fresh operands during cycles 5, 20 and 37 must all be ignored.
        exp_q.push_back(32'h0000_0000);
        start_op(2'b11, 32'd3, 32'd5);
        wait_done(1'b1, lat, busy_n);
        check("ignore_latency", 32'(lat), 32'd37);
        finish_op("ignore");
        extra = 0;
        repeat (3) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) extra++;
        end
        check("ignore_no_restart", 32'(extra), 32'd0);

        run_op("mul_7_m3", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhsu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulh_zero", 2'b01, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0);
        run_op("mulh_m1_1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;
        check("result_hold", o_result, 32'hFFFF_FFFF);

        // Abort in the middle of the shift-add phase.
        start_op(2'b00, 32'h0001_2345, 32'h0000_6789);
        repeat (11) @(posedge i_clk);
        #1;
        check("pre_abort_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        run_op("mul_6_7", 2'b00, 32'd6, 32'd7, 32'h0000_002A, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(3, 0));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(7, 0))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'd0;
                3: b = 32'h7FFF_FFFF;
                default: ;
            endcase
            run_op("random", op, a, b, ref_mul(op, a, b), 1'b0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
